// File: rtl/aq_pkg.sv
// Shared types for the aquarium pump driver: FSM states, pump select and command encodings.
package aq_pkg;

  typedef enum logic [2:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN, DEAD} state_e;
  typedef enum logic [1:0] {NONE, HOT, COLD} sel_e;

  localparam logic [1:0] CMD_OFF     = 2'b00;
  localparam logic [1:0] CMD_COLD    = 2'b01;
  localparam logic [1:0] CMD_HOT     = 2'b10;
  localparam logic [1:0] CMD_ILLEGAL = 2'b11;

  // An illegal command maps to NONE, so it behaves like OFF everywhere.
  function automatic sel_e cmd_to_sel(input logic [1:0] cmd);
    case (cmd)
      CMD_HOT:  cmd_to_sel = HOT;
      CMD_COLD: cmd_to_sel = COLD;
      default:  cmd_to_sel = NONE;
    endcase
  endfunction

endpackage

// File: rtl/aq_pwm_gen.sv
// Free-running PWM counter and duty comparator; returns the ungated pwm bit.
module aq_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_raw
);

  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (clr) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign pwm_raw = (pwm_cnt < duty);

endmodule

// File: rtl/aquarium_pump_driver.sv
// Hot/cold pump power-stage driver with soft start/stop, min on-time and dead-time.
// Optional dry-run protection is enabled with `define AQ_DRY_RUN_PROTECT_EN.
module aquarium_pump_driver
  import aq_pkg::*;
#(
  parameter int PWM_BITS         = 8,
  parameter int RAMP_STEP_CYCLES = 195312,
  parameter int MIN_ON_CYCLES    = 250000000,
  parameter int DEAD_CYCLES      = 50000000
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                cmd_hot,
  input  logic                cmd_cold,
  input  logic                water_ok,
  output logic                hot_pwm,
  output logic                cold_pwm,
  output logic                busy,
  output logic                cmd_err,
  output logic                fault,
  output logic [PWM_BITS-1:0] duty
);

  localparam int STEP_W = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
  localparam int ON_W   = $clog2(MIN_ON_CYCLES + 1);
  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(RAMP_STEP_CYCLES - 1);
  localparam logic [ON_W-1:0]     ON_MAX    = ON_W'(MIN_ON_CYCLES);
  localparam logic [DEAD_W-1:0]   DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;

  state_e              state, state_n;
  sel_e                sel, sel_n, cmd_sel;
  logic [1:0]          cmd_q;
  logic [PWM_BITS-1:0] duty_n;
  logic [STEP_W-1:0]   step_cnt, step_n;
  logic [ON_W-1:0]     on_cnt, on_n;
  logic [DEAD_W-1:0]   dead_cnt, dead_n;
  logic                step_done, dry, pwm_raw;

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      sel      <= NONE;
      cmd_q    <= CMD_OFF;
      duty     <= '0;
      step_cnt <= '0;
      on_cnt   <= '0;
      dead_cnt <= '0;
      hot_pwm  <= 1'b0;
      cold_pwm <= 1'b0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      cmd_q    <= {cmd_hot, cmd_cold};
      duty     <= duty_n;
      step_cnt <= step_n;
      on_cnt   <= on_n;
      dead_cnt <= dead_n;
      hot_pwm  <= (sel == HOT)  && pwm_raw;
      cold_pwm <= (sel == COLD) && pwm_raw;
    end
  end

  assign cmd_sel   = cmd_to_sel(cmd_q);
  assign step_done = (step_cnt == STEP_LAST);
  assign busy      = (state != IDLE);
  assign cmd_err   = cmd_q[1] & cmd_q[0];

`ifdef AQ_DRY_RUN_PROTECT_EN
  logic water_q, fault_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      water_q <= 1'b1;
      fault_q <= 1'b0;
    end else begin
      water_q <= water_ok;
      if (dry && (state == RAMP_UP || state == RUN)) fault_q <= 1'b1;
    end
  end

  assign dry   = ~water_q;
  assign fault = fault_q;
`else
  logic unused_water;
  assign unused_water = water_ok;
  assign dry          = 1'b0;
  assign fault        = 1'b0;
`endif

  always_comb begin
    state_n = state;
    sel_n   = sel;
    duty_n  = duty;
    step_n  = '0;
    on_n    = on_cnt;
    dead_n  = '0;
    case (state)
      IDLE: begin
        if (cmd_sel != NONE && !fault) begin
          state_n = RAMP_UP;
          sel_n   = cmd_sel;
          duty_n  = '0;
        end
      end
      RAMP_UP: begin
        // Abort wins over a pending step so the ramp-down starts from the current duty.
        if (cmd_sel != sel || dry) begin
          state_n = RAMP_DOWN;
        end else if (step_done) begin
          duty_n = (duty == DUTY_MAX) ? duty : duty + 1'b1;
          if (duty_n == DUTY_MAX) begin
            state_n = RUN;
            on_n    = '0;
          end
        end else begin
          step_n = step_cnt + 1'b1;
        end
      end
      RUN: begin
        on_n = (on_cnt == ON_MAX) ? on_cnt : on_cnt + 1'b1;
        if ((cmd_sel != sel && on_cnt == ON_MAX) || dry) state_n = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (step_done) begin
          duty_n = (duty == '0) ? duty : duty - 1'b1;
          if (duty_n == '0) state_n = DEAD;
        end else begin
          step_n = step_cnt + 1'b1;
        end
      end
      DEAD: begin
        if (dead_cnt == DEAD_LAST) state_n = IDLE;
        else                       dead_n  = dead_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  aq_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk     (clk),
    .clr     (clr),
    .duty    (duty),
    .pwm_raw (pwm_raw)
  );

endmodule

// File: tb/tb_aquarium_pump_driver.sv
// Scoreboard bench: stimulus queues expected {cycle, busy, cmd_err, fault, duty} events, a monitor pops on every change.
module tb_aquarium_pump_driver;

  logic       clk = 1'b0;
  logic       clr, cmd_hot, cmd_cold, water_ok;
  logic       hot_pwm, cold_pwm, busy, cmd_err, fault;
  logic [3:0] duty;

  aquarium_pump_driver #(
    .PWM_BITS(4), .RAMP_STEP_CYCLES(2), .MIN_ON_CYCLES(10), .DEAD_CYCLES(3)
  ) dut (
    .clk(clk), .clr(clr), .cmd_hot(cmd_hot), .cmd_cold(cmd_cold), .water_ok(water_ok),
    .hot_pwm(hot_pwm), .cold_pwm(cold_pwm), .busy(busy), .cmd_err(cmd_err),
    .fault(fault), .duty(duty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       b;
    logic       e;
    logic       f;
    logic [3:0] d;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         cold_hi = 0;
  bit         mon_en = 1'b0;
  logic [6:0] prev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cyc %0d: actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  task automatic push(input int c, input logic b, input logic e, input logic f, input int d);
    ev_t ev;
    ev.cyc = c; ev.b = b; ev.e = e; ev.f = f; ev.d = 4'(d);
    exp_q.push_back(ev);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: overlap invariant every cycle, event compare whenever the observed outputs change.
  always @(negedge clk) begin
    logic [6:0] cur;
    ev_t        ev;
    if (mon_en) begin
      cur = {busy, cmd_err, fault, duty};
      chk("no_overlap", 32'(hot_pwm & cold_pwm), 0);
      if (cold_pwm === 1'b1) cold_hi++;
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event at cyc %0d: actual=%h required=no change", cyc, cur);
        end else begin
          ev = exp_q.pop_front();
          chk("ev_cycle", cyc, ev.cyc);
          chk("ev_busy", 32'(busy), 32'(ev.b));
          chk("ev_cmd_err", 32'(cmd_err), 32'(ev.e));
          chk("ev_fault", 32'(fault), 32'(ev.f));
          chk("ev_duty", 32'(duty), 32'(ev.d));
        end
      end
      prev = cur;
    end
  end

  initial begin
    int hi;
    clr = 1'b1; cmd_hot = 1'b1; cmd_cold = 1'b0; water_ok = 1'b1;
    wait_cyc(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_duty", 32'(duty), 0);
    chk("rst_hot", 32'(hot_pwm), 0);
    chk("rst_cold", 32'(cold_pwm), 0);
    chk("rst_cmd_err", 32'(cmd_err), 0);
    chk("rst_fault", 32'(fault), 0);
    prev   = {busy, cmd_err, fault, duty};
    mon_en = 1'b1;

    // Hot start: registered at edge 4, RAMP_UP at 5, +1 duty every 2 cycles, RUN at 35.
    clr = 1'b0;
    push(5, 1, 0, 0, 0);
    for (int k = 1; k <= 15; k++) push(5 + 2 * k, 1, 0, 0, k);
    hi = 0;
    for (int i = 37; i <= 52; i++) begin
      wait_cyc(i);
      if (hot_pwm === 1'b1) hi++;
    end
    chk("hot_pwm_high_of_16", hi, 15);

    // Min-on already met: stop ramps down at once, DEAD 84..86, IDLE at 87.
    cmd_hot = 1'b0;
    for (int j = 1; j <= 15; j++) push(54 + 2 * j, 1, 0, 0, 15 - j);
    push(87, 0, 0, 0, 0);
    wait_cyc(87);
    chk("cold_quiet_during_hot", cold_hi, 0);

    // Hot start aborted at duty 6 by a swap to cold.
    cmd_hot = 1'b1;
    push(89, 1, 0, 0, 0);
    for (int k = 1; k <= 6; k++) push(89 + 2 * k, 1, 0, 0, k);
    wait_cyc(101);
    cmd_hot = 1'b0; cmd_cold = 1'b1;
    for (int j = 1; j <= 6; j++) push(103 + 2 * j, 1, 0, 0, 6 - j);
    push(118, 0, 0, 0, 0);
    push(119, 1, 0, 0, 0);
    for (int k = 1; k <= 15; k++) push(119 + 2 * k, 1, 0, 0, k);

    // Illegal command 2 cycles into cold RUN (entered 149): min-on holds RUN until edge 160.
    wait_cyc(151);
    cmd_hot = 1'b1;
    push(152, 1, 1, 0, 15);
    for (int j = 1; j <= 15; j++) push(160 + 2 * j, 1, 1, 0, 15 - j);
    push(193, 0, 1, 0, 0);
    wait_cyc(193);
    chk("cold_pump_driven", 32'(cold_hi > 0), 1);

    // Illegal command from IDLE: cmd_err only, no pump start.
    cmd_hot = 1'b0; cmd_cold = 1'b0;
    push(194, 0, 0, 0, 0);
    wait_cyc(200);
    cmd_hot = 1'b1; cmd_cold = 1'b1;
    push(201, 0, 1, 0, 0);
    wait_cyc(210);
    cmd_hot = 1'b0; cmd_cold = 1'b0;
    push(211, 0, 0, 0, 0);

`ifdef AQ_DRY_RUN_PROTECT_EN
    // Dry run in RUN bypasses min-on, latches fault and blocks the next start until clr.
    wait_cyc(220);
    cmd_hot = 1'b1;
    push(222, 1, 0, 0, 0);
    for (int k = 1; k <= 15; k++) push(222 + 2 * k, 1, 0, 0, k);
    wait_cyc(255);
    water_ok = 1'b0;
    push(257, 1, 0, 1, 15);
    for (int j = 1; j <= 15; j++) push(257 + 2 * j, 1, 0, 1, 15 - j);
    push(290, 0, 0, 1, 0);
    wait_cyc(256);
    water_ok = 1'b1;
    wait_cyc(260);
    cmd_hot = 1'b0; cmd_cold = 1'b1;
    wait_cyc(300);
    clr = 1'b1;
    push(301, 0, 0, 0, 0);
    wait_cyc(301);
    clr = 1'b0;
    push(303, 1, 0, 0, 0);
    push(305, 1, 0, 0, 1);
    wait_cyc(305);
    clr = 1'b1;
    push(306, 0, 0, 0, 0);
`endif

    wait_cyc(320);
    chk("events_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
